// File: rtl/demux1t4_8b_stream_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer and its 4:1 selector twin.
package demux1t4_8b_stream_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // Channel indices, common with the 4:1 selector
    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

    // One-hot decode of a channel select
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        sel_decode = NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux1t4_8b_stream_slot.sv
// One-entry holding register for a single demux output channel.
// Optional drain counter is built when DEMUX1T4_CNT_EN is defined.
module demux1t4_8b_stream_slot
#(
    parameter int unsigned WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             out_ready,
    output logic             ready_up
`ifdef DEMUX1T4_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [7:0]       cnt
`endif
);

    logic drain;
    logic load_ok;

    // Slot can take a new word when empty or being emptied this cycle
    assign ready_up = ~valid | out_ready;
    assign drain    = valid & out_ready;
    // A load is never allowed to overwrite an undelivered word
    assign load_ok  = load & ready_up;

    // Holding register: load wins over drain so the slot stays full on pass-through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load_ok) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

`ifdef DEMUX1T4_CNT_EN
    // Drain counter, wraps 255->0; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (cnt_clr) begin
            cnt <= 8'd0;
        end else if (drain) begin
            cnt <= 8'(cnt + 8'd1);
        end
    end
`endif

endmodule

// File: rtl/demux1t4_8b_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// Each channel has its own one-entry slot, so a stalled consumer only blocks
// words addressed to it. Define DEMUX1T4_CNT_EN to add per-channel drain
// counters (cnt0..cnt3) and the cnt_clr input.
module demux1t4_8b_stream
    import demux1t4_8b_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       Sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] F0,
    output logic [WIDTH-1:0] F1,
    output logic [WIDTH-1:0] F2,
    output logic [WIDTH-1:0] F3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX1T4_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
`endif
);

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] ready_up;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
`ifdef DEMUX1T4_CNT_EN
    logic [7:0]        slot_cnt  [NUM_CH];
`endif

    // Steer the offered word to the selected slot; a don't-care Sel while idle loads nothing
    always_comb begin
        load = '0;
        if (in_valid) begin
            load = sel_decode(Sel) & {NUM_CH{in_ready}};
        end
    end

    // Readiness follows only the currently selected channel
    assign in_ready = ready_up[Sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux1t4_8b_stream_slot #(
            .WIDTH     (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .data      (slot_data[k]),
            .valid     (out_valid[k]),
            .out_ready (out_ready[k]),
            .ready_up  (ready_up[k])
`ifdef DEMUX1T4_CNT_EN
            ,
            .cnt_clr   (cnt_clr),
            .cnt       (slot_cnt[k])
`endif
        );
    end

    assign F0 = slot_data[CH0];
    assign F1 = slot_data[CH1];
    assign F2 = slot_data[CH2];
    assign F3 = slot_data[CH3];

`ifdef DEMUX1T4_CNT_EN
    assign cnt0 = slot_cnt[CH0];
    assign cnt1 = slot_cnt[CH1];
    assign cnt2 = slot_cnt[CH2];
    assign cnt3 = slot_cnt[CH3];
`endif

endmodule

// File: tb/tb_demux1t4_8b_stream.sv
// Directed bench for demux1t4_8b_stream with hand-computed expectations.
// Counter checks are compiled in when DEMUX1T4_CNT_EN is defined.
module tb_demux1t4_8b_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] Sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] F0, F1, F2, F3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
`ifdef DEMUX1T4_CNT_EN
    logic       cnt_clr;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux1t4_8b_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .Sel       (Sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F0        (F0),
        .F1        (F1),
        .F2        (F2),
        .F3        (F3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX1T4_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        Sel       = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
`ifdef DEMUX1T4_CNT_EN
        cnt_clr   = 1'b0;
`endif
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_F0", 32'(F0), 32'h0);
        check("rst_F3", 32'(F3), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Test 1: load channels 1 and 3, then reset mid-transfer
        in_valid = 1'b1; Sel = 2'd1; in_data = 8'h11;
        step();
        Sel = 2'd3; in_data = 8'h33;
        step();
        in_valid = 1'b0;
        check("t1_out_valid_1010", 32'(out_valid), 32'hA);
        check("t1_F1", 32'(F1), 32'h11);
        check("t1_F3", 32'(F3), 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_clear", 32'(out_valid), 32'h0);
        check("t1_F1_zero", 32'(F1), 32'h0);
        check("t1_F3_zero", 32'(F3), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("t1_in_ready_after", 32'(in_ready), 32'h1);

        // Test 2: single routing to channel 2
        in_data = 8'hA5; Sel = 2'd2; in_valid = 1'b1; out_ready = 4'b0000;
        #1;
        check("t2_in_ready_empty", 32'(in_ready), 32'h1);
        step();
        check("t2_F2", 32'(F2), 32'hA5);
        check("t2_out_valid", 32'(out_valid), 32'h4);
        check("t2_in_ready_full", 32'(in_ready), 32'h0);
        Sel = 2'd1;
        #1;
        check("t2_in_ready_sel1", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        // Idle with a don't-care select must not disturb anything
        Sel = 2'bxx;
        step();
        check("t2_idle_x_sel", 32'(out_valid), 32'h4);
        check("t2_idle_F2", 32'(F2), 32'hA5);
        Sel = 2'd0;
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        check("t2_drain", 32'(out_valid), 32'h0);
        check("t2_F2_retained", 32'(F2), 32'hA5);

        // Test 3: back-to-back streaming on channel 3
        out_ready = 4'b1000; Sel = 2'd3; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            #1;
            check($sformatf("t3_in_ready_%0d", i), 32'(in_ready), 32'h1);
            step();
            check($sformatf("t3_F3_%0d", i), 32'(F3), 32'(i));
            check($sformatf("t3_valid_%0d", i), 32'(out_valid), 32'h8);
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        check("t3_empty", 32'(out_valid), 32'h0);

        // Test 4: backpressure hold on channel 0
        Sel = 2'd0; in_data = 8'h3C; in_valid = 1'b1;
        step();
        check("t4_F0_load", 32'(F0), 32'h3C);
        in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4_in_ready_%0d", i), 32'(in_ready), 32'h0);
            step();
            check($sformatf("t4_F0_hold_%0d", i), 32'(F0), 32'h3C);
        end
        out_ready = 4'b0001;
        #1;
        check("t4_in_ready_rel", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        check("t4_F0_new", 32'(F0), 32'h77);
        check("t4_valid", 32'(out_valid), 32'h1);
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        check("t4_drained", 32'(out_valid), 32'h0);

        // Test 5: drain ch1 while accepting into ch0 in the same cycle
        Sel = 2'd1; in_data = 8'h5A; in_valid = 1'b1;
        step();
        check("t5_F1_load", 32'(out_valid), 32'h2);
        Sel = 2'd0; in_data = 8'h9E; out_ready = 4'b0010;
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        check("t5_valid", 32'(out_valid), 32'h1);
        check("t5_F0", 32'(F0), 32'h9E);
        check("t5_F1_retained", 32'(F1), 32'h5A);
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        check("t5_empty", 32'(out_valid), 32'h0);

`ifdef DEMUX1T4_CNT_EN
        // Test 6: drain counters
        check("t6_cnt0_pre", 32'(cnt0), 32'h3);
        check("t6_cnt2_pre", 32'(cnt2), 32'h1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("t6_cnt2_clr", 32'(cnt2), 32'h0);
        check("t6_cnt0_clr", 32'(cnt0), 32'h0);
        // 257 accepts on ch2 with ready held: 256 overlapped drains plus the final one
        Sel = 2'd2; in_valid = 1'b1; out_ready = 4'b0100;
        for (int i = 0; i < 257; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        check("t6_cnt2_wrap", 32'(cnt2), 32'h1);
        check("t6_cnt0_idle", 32'(cnt0), 32'h0);
        check("t6_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b1; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        out_ready = 4'b0100; cnt_clr = 1'b1;
        step();
        out_ready = 4'b0000; cnt_clr = 1'b0;
        check("t6_clr_wins", 32'(cnt2), 32'h0);
        check("t6_drained", 32'(out_valid), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
